// File: rtl/seq_shifter.sv
// Iterative shift/rotate unit: moves the operand one bit position per clock
// behind a start/busy/done handshake, mirroring the combinational shifter's semantics.
`timescale 1ns/1ps

module seq_shifter #(
    parameter int WIDTH = 8,
    parameter int NW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [NW-1:0]    n,
    input  logic             dir,
    input  logic             rot,
    output logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done
);

    localparam int            CW      = NW + 1;
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW-1:0] MASK_C  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CW-1:0]    n_ext;
    logic [CW-1:0]    k;
    logic [WIDTH-1:0] step;

    // Rotation is periodic in WIDTH; a logical shift saturates at WIDTH (all zeros).
    always_comb begin
        n_ext = {1'b0, n};
        if (rot) begin
            k = n_ext & MASK_C;
        end else begin
            k = (n_ext >= WIDTH_C) ? WIDTH_C : n_ext;
        end
    end

    always_comb begin
        if (dir_q) begin
            step = {sreg_q[WIDTH-2:0], rot_q ? sreg_q[WIDTH-1] : 1'b0};
        end else begin
            step = {rot_q ? sreg_q[0] : 1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path through the case infers a latch.
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        y_d     = y_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sreg_d  = a;
                    dir_d   = dir;
                    rot_d   = rot;
                    cnt_d   = k;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    sreg_d = step;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    y_d     = sreg_q;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
